// File: rtl/arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and grant owner.
package arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GntIf = 1'b0,
        GntDm = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Memory-latency down-counter: loaded at ISSUE, flags the final WAIT cycle.
module arb_wait_counter #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Parks at zero once expired so it never wraps between transactions.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and MEM stage access to one single-port memory and drives the pipeline stall.
// Optional ARB_PERF_CNT_EN adds saturating stall_cycles and conflicts counters.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       conflicts
`endif
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);

    arb_state_e state_q, state_d;
    arb_gnt_e   gnt_q, gnt_d;
    arb_gnt_e   last_q, last_d;
    logic       grant, both_req, cnt_load, cnt_done, capture, store_q;

    assign both_req = if_req & dm_req;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        grant    = 1'b0;
        cnt_load = 1'b0;
        capture  = 1'b0;
        case (state_q)
            StIdle: begin
                if (if_req || dm_req) begin
                    grant   = 1'b1;
                    state_d = StIssue;
                    // On conflict DM wins unless it won last time, so fetch never starves.
                    if (both_req) begin
                        gnt_d = (last_q == GntDm) ? GntIf : GntDm;
                    end else begin
                        gnt_d = dm_req ? GntDm : GntIf;
                    end
                    last_d = gnt_d;
                end
            end
            StIssue: begin
                cnt_load = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (cnt_done) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            gnt_q   <= GntIf;
            last_q  <= GntIf;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            store_q   <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en   <= grant;
            mem_we   <= grant && (gnt_d == GntDm) && dm_we;
            if_valid <= capture && (gnt_q == GntIf);
            dm_valid <= capture && (gnt_q == GntDm);
            if (grant) begin
                mem_addr <= (gnt_d == GntDm) ? dm_addr : if_addr;
                store_q  <= (gnt_d == GntDm) && dm_we;
                if (gnt_d == GntDm) begin
                    mem_wdata <= dm_wdata;
                end
            end
            if (capture && (gnt_q == GntIf)) begin
                if_rdata <= mem_rdata;
            end
            if (capture && (gnt_q == GntDm) && !store_q) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    arb_wait_counter #(
        .CNT_W (CntW)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CntW'(MEM_LAT)),
        .done     (cnt_done)
    );

    // Forced low during reset so every output is quiet while rst is held.
    assign stall = rst & ((if_req & ~if_valid) | (dm_req & ~dm_valid));

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            conflicts    <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (grant && both_req && (conflicts != 32'hFFFF_FFFF)) begin
                conflicts <= conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: cycle-scheduled transaction model plus directed
// scenarios; a second instance with MEM_LAT=3 covers the longer wait.
module tb_unified_mem_arbiter;

    localparam int unsigned AW  = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_valid, dm_valid, mem_en, mem_we, stall;
    logic [AW-1:0] mem_addr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   stall_cycles, conflicts;
`endif

    logic          if_req_3;
    logic [AW-1:0] if_addr_3;
    logic          zero_1;
    logic [AW-1:0] zero_a;
    logic [DW-1:0] zero_d;
    logic [DW-1:0] if_rdata_3, dm_rdata_3, mem_wdata_3, mem_rdata_3;
    logic          if_valid_3, dm_valid_3, mem_en_3, mem_we_3, stall_3;
    logic [AW-1:0] mem_addr_3;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   stall_cycles_3, conflicts_3;
`endif

    int tests = 0;
    int fails = 0;

    // Bench memory: fixed contents overlaid with whatever the DUT stores.
    logic [DW-1:0] wr_data [64];
    bit   [63:0]   wr_valid = '0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        case (a)
            6'd5:    return 32'h00A0_0093;
            6'd7:    return 32'h0000_7777;
            6'd9:    return 32'h1234_5678;
            default: return 32'hC0DE_0000 | {26'd0, a};
        endcase
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return wr_valid[a] ? wr_data[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_data[mem_addr]  <= mem_wdata;
            wr_valid[mem_addr] <= 1'b1;
        end
    end

    always_comb mem_rdata = wr_valid[mem_addr] ? wr_data[mem_addr] : init_word(mem_addr);
    always_comb mem_rdata_3 = init_word(mem_addr_3);

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .conflicts(conflicts)
`endif
    );

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_3 (
        .clk(clk), .rst(rst),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_rdata(if_rdata_3), .if_valid(if_valid_3),
        .dm_req(zero_1), .dm_we(zero_1), .dm_addr(zero_a), .dm_wdata(zero_d),
        .dm_rdata(dm_rdata_3), .dm_valid(dm_valid_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .stall(stall_3)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles_3), .conflicts(conflicts_3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: a grant at IDLE cycle tg issues at tg+1, completes at tg+LAT+2,
    // and the arbiter is free again at tg+LAT+3.
    int            cyc = 0;
    int            m_tg;
    bit            m_busy, m_gnt_dm, m_last_dm, m_store;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rd, m_dm_rd;
    logic [31:0]   m_stall_cnt, m_conf;
    bit            done_now, e_en, e_if_v, e_dm_v, e_stall;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_last_dm = 0; m_if_rd = '0; m_dm_rd = '0;
            m_stall_cnt = '0; m_conf = '0;
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_if_valid", if_valid, 0);
            check("rst_dm_valid", dm_valid, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_dm_rdata", dm_rdata, 0);
            check("rst_stall", stall, 0);
`ifdef ARB_PERF_CNT_EN
            check("rst_stall_cycles", stall_cycles, 0);
            check("rst_conflicts", conflicts, 0);
`endif
        end else begin
            done_now = m_busy && (cyc == m_tg + LAT + 2);
            if (done_now && !m_store) begin
                if (m_gnt_dm) m_dm_rd = mem_word(m_addr);
                else          m_if_rd = mem_word(m_addr);
            end
            e_en    = m_busy && (cyc == m_tg + 1);
            e_if_v  = done_now && !m_gnt_dm;
            e_dm_v  = done_now && m_gnt_dm;
            e_stall = (if_req && !e_if_v) || (dm_req && !e_dm_v);
            check("m_mem_en", mem_en, e_en);
            check("m_mem_we", mem_we, e_en && m_store);
            if (e_en) check("m_mem_addr", mem_addr, m_addr);
            if (e_en && m_store) check("m_mem_wdata", mem_wdata, m_wdata);
            check("m_if_valid", if_valid, e_if_v);
            check("m_dm_valid", dm_valid, e_dm_v);
            check("m_if_rdata", if_rdata, m_if_rd);
            check("m_dm_rdata", dm_rdata, m_dm_rd);
            check("m_stall", stall, e_stall);
`ifdef ARB_PERF_CNT_EN
            check("m_stall_cycles", stall_cycles, m_stall_cnt);
            check("m_conflicts", conflicts, m_conf);
`endif
            if (e_stall) m_stall_cnt++;
            if (done_now) begin
                m_busy = 0;
            end else if (!m_busy && (if_req || dm_req)) begin
                if (if_req && dm_req) begin
                    m_gnt_dm = !m_last_dm;
                    m_conf++;
                end else begin
                    m_gnt_dm = dm_req;
                end
                m_last_dm = m_gnt_dm;
                m_tg      = cyc;
                m_busy    = 1;
                m_store   = m_gnt_dm && dm_we;
                m_addr    = m_gnt_dm ? dm_addr : if_addr;
                m_wdata   = dm_wdata;
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int          nv, if_v1, if_v2;
    logic [3:0]  seq;

    initial begin
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req_3 = 0; if_addr_3 = '0; zero_1 = 0; zero_a = '0; zero_d = '0;
        rst = 0;
        repeat (3) @(posedge clk);
        mid();
        rst = 1;
        next_cycle();

        // Single fetch, MEM_LAT=1.
        if_req = 1; if_addr = 6'd5;
        for (int k = 0; k < 4; k++) begin
            mid();
            check("t1_stall", stall, k < 3);
            check("t1_mem_en", mem_en, k == 1);
            if (k == 1) check("t1_mem_addr", mem_addr, 5);
            check("t1_if_valid", if_valid, k == 3);
            if (k == 3) begin
                check("t1_if_rdata", if_rdata, 32'h00A0_0093);
                if_req = 0;
            end
            next_cycle();
        end

        // Simultaneous requests: DM first, IF right after.
        if_req = 1; if_addr = 6'd2; dm_req = 1; dm_we = 0; dm_addr = 6'd9;
        for (int k = 0; k < 8; k++) begin
            mid();
            check("t2_mem_en", mem_en, (k == 1) || (k == 5));
            if (k == 1) check("t2_dm_addr", mem_addr, 9);
            if (k == 5) check("t2_if_addr", mem_addr, 2);
            check("t2_dm_valid", dm_valid, k == 3);
            check("t2_if_valid", if_valid, k == 7);
            if (k == 3) begin
                check("t2_dm_rdata", dm_rdata, 32'h1234_5678);
                dm_req = 0;
            end
            if (k == 7) begin
                check("t2_if_rdata", if_rdata, 32'hC0DE_0002);
                if_req = 0;
            end
            next_cycle();
        end
`ifdef ARB_PERF_CNT_EN
        check("t2_conflicts", conflicts, 1);
`endif

        // Continuous dual stream alternates DM, IF, DM, IF.
        if_req = 1; if_addr = 6'd1; dm_req = 1; dm_addr = 6'd2;
        nv = 0; seq = '0; if_v1 = 0; if_v2 = 0;
        for (int k = 0; k < 40 && nv < 4; k++) begin
            mid();
            if (if_valid || dm_valid) begin
                seq = {seq[2:0], dm_valid};
                if (if_valid) begin
                    if (if_v1 == 0) if_v1 = k;
                    else            if_v2 = k;
                end
                nv++;
                if (nv == 4) begin
                    if_req = 0; dm_req = 0;
                end
            end
            next_cycle();
        end
        check("t3_valid_count", nv, 4);
        check("t3_grant_order", {28'd0, seq}, 32'hA);
        check("t3_if_gap", if_v2 - if_v1, 8);
`ifdef ARB_PERF_CNT_EN
        check("t3_conflicts", conflicts, 5);
`endif

        // Store leaves dm_rdata alone.
        dm_req = 1; dm_we = 1; dm_addr = 6'd3; dm_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            mid();
            check("t4_mem_en", mem_en, k == 1);
            check("t4_mem_we", mem_we, k == 1);
            if (k == 1) begin
                check("t4_mem_addr", mem_addr, 3);
                check("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            check("t4_dm_valid", dm_valid, k == 3);
            check("t4_dm_rdata_kept", dm_rdata, 32'hC0DE_0002);
            if (k == 3) begin
                dm_req = 0; dm_we = 0;
            end
            next_cycle();
        end
        check("t4_mem_written", mem_word(6'd3), 32'hDEAD_BEEF);

        // Read back the stored word.
        dm_req = 1; dm_addr = 6'd3;
        for (int k = 0; k < 4; k++) begin
            mid();
            if (k == 3) begin
                check("t4b_dm_valid", dm_valid, 1);
                check("t4b_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
                dm_req = 0;
            end
            next_cycle();
        end

        // Reset in WAIT, then priority must be back to DM.
        dm_req = 1; dm_addr = 6'd9;
        mid();
        next_cycle();
        mid();
        check("t6_issue", mem_en, 1);
        next_cycle();
        mid();
        check("t6_pre_rdata", dm_rdata, 32'hDEAD_BEEF);
        rst = 0;
        #1;
        check("t6_async_mem_en", mem_en, 0);
        check("t6_async_mem_addr", mem_addr, 0);
        check("t6_async_if_valid", if_valid, 0);
        check("t6_async_dm_valid", dm_valid, 0);
        check("t6_async_if_rdata", if_rdata, 0);
        check("t6_async_dm_rdata", dm_rdata, 0);
        check("t6_async_stall", stall, 0);
        dm_req = 0;
        next_cycle();
        mid();
        rst = 1;
        next_cycle();
        if_req = 1; if_addr = 6'd6; dm_req = 1; dm_addr = 6'd4;
        for (int k = 0; k < 8; k++) begin
            mid();
            if (k == 1) begin
                check("t6_first_en", mem_en, 1);
                check("t6_dm_priority", mem_addr, 4);
            end
            if (k == 3) begin
                check("t6_dm_valid", dm_valid, 1);
                check("t6_dm_rdata", dm_rdata, 32'hC0DE_0004);
                dm_req = 0;
            end
            if (k == 7) begin
                check("t6_if_valid", if_valid, 1);
                check("t6_if_rdata", if_rdata, 32'hC0DE_0006);
                if_req = 0;
            end
            next_cycle();
        end
`ifdef ARB_PERF_CNT_EN
        check("t6_conflicts", conflicts, 1);
`endif

        // MEM_LAT=3 instance: three WAIT cycles, valid at T+5.
        if_req_3 = 1; if_addr_3 = 6'd7;
        for (int k = 0; k < 6; k++) begin
            mid();
            check("t5_mem_en", mem_en_3, k == 1);
            check("t5_mem_we", mem_we_3, 0);
            if (k == 1) check("t5_mem_addr", mem_addr_3, 7);
            check("t5_if_valid", if_valid_3, k == 5);
            check("t5_dm_valid", dm_valid_3, 0);
            check("t5_stall", stall_3, k < 5);
            if (k == 5) begin
                check("t5_if_rdata", if_rdata_3, 32'h0000_7777);
                if_req_3 = 0;
            end
            next_cycle();
        end
        check("t5_dm_rdata", dm_rdata_3, 0);

        repeat (3) next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
